ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-ported memory between a CPU instruction port
// and a CPU data port. One access is in flight at a time. The memory-side
// outputs come from registers latched when an access is granted.
// Optional build macro RAM_ARB_RR_EN: when both ports ask at once, the port
// not granted last wins. Without it, the data port always wins ties.
module ram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dren,
  input  logic [3:0]  dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ACC  = 3'd1,
    D_ACC  = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;

  logic        ireq_s;
  logic        dreq_s;
  logic        grant_i_s;
  logic        grant_d_s;

  logic        mem_req_r;
  logic [3:0]  mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [31:0] iload_r;
  logic [31:0] dload_r;

  // The memory is word addressed; the byte offset bits are dropped.
  logic        unused_addr_bits_s;
  assign unused_addr_bits_s = ^{iaddr[1:0], daddr[1:0]};

  // A data request is either a read or any byte write.
  assign ireq_s = iren;
  assign dreq_s = dren | (|dwen);

`ifdef RAM_ARB_RR_EN
  // Remembers which port received the most recent grant (1 = data).
  logic last_d_r;

  // Track the last granted port; reset makes the instruction port win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_r <= 1'b1;
    end else if (grant_d_s) begin
      last_d_r <= 1'b1;
    end else if (grant_i_s) begin
      last_d_r <= 1'b0;
    end
  end
`endif

  // Pick which port gets the memory when the arbiter is idle.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (dreq_s && ireq_s) begin
`ifdef RAM_ARB_RR_EN
        if (last_d_r) begin
          grant_i_s = 1'b1;
        end else begin
          grant_d_s = 1'b1;
        end
`else
        grant_d_s = 1'b1;
`endif
      end else if (dreq_s) begin
        grant_d_s = 1'b1;
      end else if (ireq_s) begin
        grant_i_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic. An access whose requester has gone away still runs to
  // completion on the memory, but returns straight to IDLE with no DONE cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_nx_s = D_ACC;
        end else if (grant_i_s) begin
          state_nx_s = I_ACC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      I_ACC: begin
        if (mem_ready) begin
          if (ireq_s) begin
            state_nx_s = I_DONE;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = I_ACC;
        end
      end
      D_ACC: begin
        if (mem_ready) begin
          if (dreq_s) begin
            state_nx_s = D_DONE;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = D_ACC;
        end
      end
      I_DONE:  state_nx_s = IDLE;
      D_DONE:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Latch the access on grant, drop the request on completion, capture read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 4'b0000;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      iload_r     <= 32'h0000_0013;
      dload_r     <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_d_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= dwen;
            mem_addr_r  <= {daddr[31:2], 2'b00};
            mem_wdata_r <= dstore;
          end else if (grant_i_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 4'b0000;
            mem_addr_r  <= {iaddr[31:2], 2'b00};
            mem_wdata_r <= 32'h0000_0000;
          end
        end
        I_ACC: begin
          if (mem_ready) begin
            mem_req_r <= 1'b0;
            if (ireq_s) begin
              iload_r <= mem_rdata;
            end
          end
        end
        D_ACC: begin
          if (mem_ready) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 4'b0000;
            // Writes never touch dload; abandoned reads are discarded.
            if (dreq_s && (mem_we_r == 4'b0000)) begin
              dload_r <= mem_rdata;
            end
          end
        end
        default: begin
          mem_req_r <= mem_req_r;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign iload     = iload_r;
  assign dload     = dload_r;

  // Each wait drops for exactly the one DONE cycle of its port.
  assign iwait = ireq_s & (state_r != I_DONE);
  assign dwait = dreq_s & (state_r != D_DONE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a hand-computed vector table, directed
// sequences for ties, reset mid-access and abandoned requests, and a random
// phase compared against a transaction-level reference model.
module tb_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        iren;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dren;
  logic [3:0]  dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int tests;
  int failed;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .iren(iren), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iwait;
    logic        e_dwait;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t row(
    input logic i, input logic [31:0] ia, input logic d, input logic [3:0] w,
    input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rd, input logic rdy,
    input logic q, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd,
    input logic iw, input logic dw, input logic [31:0] il, input logic [31:0] dl);
    vec_t v;
    v.iren = i; v.iaddr = ia; v.dren = d; v.dwen = w; v.daddr = da; v.dstore = ds;
    v.rdata = rd; v.ready = rdy; v.e_req = q; v.e_we = we; v.e_addr = a; v.e_wdata = wd;
    v.e_iwait = iw; v.e_dwait = dw; v.e_iload = il; v.e_dload = dl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic i, input logic [31:0] ia, input logic d, input logic [3:0] w,
                       input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rd,
                       input logic rdy);
    iren = i; iaddr = ia; dren = d; dwen = w; daddr = da; dstore = ds;
    mem_rdata = rd; mem_ready = rdy;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point of the current cycle.
  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic        m_busy;
  logic        m_is_d;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_we;
  int          m_done;   // 0: none, 1: instruction finished, 2: data finished
  logic [31:0] m_iload;
  logic [31:0] m_dload;
`ifdef RAM_ARB_RR_EN
  logic        m_last_d;
`endif

  task automatic model_reset();
    m_busy = 1'b0; m_is_d = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_we = 4'h0;
    m_done = 0; m_iload = 32'h0000_0013; m_dload = 32'h0;
`ifdef RAM_ARB_RR_EN
    m_last_d = 1'b1;
`endif
  endtask

  task automatic model_check(input int c);
    logic dq;
    dq = dren | (|dwen);
    chk($sformatf("rnd%0d mem_req", c), {31'h0, mem_req}, {31'h0, m_busy});
    chk($sformatf("rnd%0d mem_we", c), {28'h0, mem_we}, {28'h0, (m_busy ? m_we : 4'h0)});
    chk($sformatf("rnd%0d mem_addr", c), mem_addr, m_addr);
    chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, m_wdata);
    chk($sformatf("rnd%0d iwait", c), {31'h0, iwait}, {31'h0, (iren && (m_done != 1))});
    chk($sformatf("rnd%0d dwait", c), {31'h0, dwait}, {31'h0, (dq && (m_done != 2))});
    chk($sformatf("rnd%0d iload", c), iload, m_iload);
    chk($sformatf("rnd%0d dload", c), dload, m_dload);
  endtask

  // Effect of one clock edge on the outstanding transaction.
  task automatic model_step();
    logic dq;
    logic pick_d;
    dq = dren | (|dwen);
    if (m_done != 0) begin
      m_done = 0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_busy = 1'b0;
        if (m_is_d ? dq : iren) begin
          m_done = m_is_d ? 2 : 1;
          if (!m_is_d) m_iload = mem_rdata;
          else if (m_we == 4'h0) m_dload = mem_rdata;
        end
      end
    end else if (dq || iren) begin
      if (dq && iren) begin
`ifdef RAM_ARB_RR_EN
        pick_d = !m_last_d;
`else
        pick_d = 1'b1;
`endif
      end else begin
        pick_d = dq;
      end
`ifdef RAM_ARB_RR_EN
      m_last_d = pick_d;
`endif
      m_busy = 1'b1;
      m_is_d = pick_d;
      if (pick_d) begin
        m_addr = daddr & 32'hFFFF_FFFC; m_we = dwen; m_wdata = dstore;
      end else begin
        m_addr = iaddr & 32'hFFFF_FFFC; m_we = 4'h0; m_wdata = 32'h0;
      end
    end
  endtask

  logic        first_d;
  logic [31:0] first_addr;
  logic [31:0] second_addr;

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // ---------------- reset state ----------------
    smp();
    smp();
    chk("reset mem_req", {31'h0, mem_req}, 32'h0);
    chk("reset mem_we", {28'h0, mem_we}, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset iload", iload, 32'h0000_0013);
    chk("reset dload", dload, 32'h0);
    cyc();
    rst = 1'b0;

    // ---------------- vector table ----------------
    //            iren iaddr          dren dwen     daddr          dstore         rdata          rdy  | req  we       addr           wdata          iw   dw   iload          dload
    tbl[0]  = row(1'b1, 32'h0000_0104, 1'b0, 4'b0000, 32'h0,         32'h0,         32'hDEAD_0001, 1'b1, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0013, 32'h0);
    tbl[1]  = row(1'b1, 32'h0000_0104, 1'b0, 4'b0000, 32'h0,         32'h0,         32'hDEAD_0001, 1'b1, 1'b1, 4'b0000, 32'h0000_0104, 32'h0,         1'b1, 1'b0, 32'h0000_0013, 32'h0);
    tbl[2]  = row(1'b1, 32'h0000_0104, 1'b0, 4'b0000, 32'h0,         32'h0,         32'hDEAD_0001, 1'b1, 1'b0, 4'b0000, 32'h0000_0104, 32'h0,         1'b0, 1'b0, 32'hDEAD_0001, 32'h0);
    tbl[3]  = row(1'b0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 4'b0000, 32'h0000_0104, 32'h0,         1'b0, 1'b0, 32'hDEAD_0001, 32'h0);
    tbl[4]  = row(1'b0, 32'h0,         1'b0, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h0,         1'b0, 1'b0, 4'b0000, 32'h0000_0104, 32'h0,         1'b0, 1'b1, 32'hDEAD_0001, 32'h0);
    tbl[5]  = row(1'b0, 32'h0,         1'b0, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h0,         1'b0, 1'b1, 4'b0100, 32'h0000_2000, 32'h00AB_0000, 1'b0, 1'b1, 32'hDEAD_0001, 32'h0);
    tbl[6]  = tbl[5];
    tbl[7]  = tbl[5];
    tbl[8]  = row(1'b0, 32'h0,         1'b0, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h5555_5555, 1'b1, 1'b1, 4'b0100, 32'h0000_2000, 32'h00AB_0000, 1'b0, 1'b1, 32'hDEAD_0001, 32'h0);
    tbl[9]  = row(1'b0, 32'h0,         1'b0, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h5555_5555, 1'b1, 1'b0, 4'b0000, 32'h0000_2000, 32'h00AB_0000, 1'b0, 1'b0, 32'hDEAD_0001, 32'h0);
    tbl[10] = row(1'b0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 4'b0000, 32'h0000_2000, 32'h00AB_0000, 1'b0, 1'b0, 32'hDEAD_0001, 32'h0);
    tbl[11] = row(1'b0, 32'h0,         1'b1, 4'b0000, 32'h0000_3008, 32'h0,         32'h1234_5678, 1'b1, 1'b0, 4'b0000, 32'h0000_2000, 32'h00AB_0000, 1'b0, 1'b1, 32'hDEAD_0001, 32'h0);
    tbl[12] = row(1'b0, 32'h0,         1'b1, 4'b0000, 32'h0000_3008, 32'h0,         32'h1234_5678, 1'b1, 1'b1, 4'b0000, 32'h0000_3008, 32'h0,         1'b0, 1'b1, 32'hDEAD_0001, 32'h0);
    tbl[13] = row(1'b0, 32'h0,         1'b1, 4'b0000, 32'h0000_3008, 32'h0,         32'h1234_5678, 1'b1, 1'b0, 4'b0000, 32'h0000_3008, 32'h0,         1'b0, 1'b0, 32'hDEAD_0001, 32'h1234_5678);
    tbl[14] = row(1'b0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 4'b0000, 32'h0000_3008, 32'h0,         1'b0, 1'b0, 32'hDEAD_0001, 32'h1234_5678);

    for (int k = 0; k < 15; k++) begin
      cyc();
      drive(tbl[k].iren, tbl[k].iaddr, tbl[k].dren, tbl[k].dwen, tbl[k].daddr,
            tbl[k].dstore, tbl[k].rdata, tbl[k].ready);
      smp();
      chk($sformatf("row%0d mem_req", k), {31'h0, mem_req}, {31'h0, tbl[k].e_req});
      chk($sformatf("row%0d mem_we", k), {28'h0, mem_we}, {28'h0, tbl[k].e_we});
      chk($sformatf("row%0d mem_addr", k), mem_addr, tbl[k].e_addr);
      chk($sformatf("row%0d mem_wdata", k), mem_wdata, tbl[k].e_wdata);
      chk($sformatf("row%0d iwait", k), {31'h0, iwait}, {31'h0, tbl[k].e_iwait});
      chk($sformatf("row%0d dwait", k), {31'h0, dwait}, {31'h0, tbl[k].e_dwait});
      chk($sformatf("row%0d iload", k), iload, tbl[k].e_iload);
      chk($sformatf("row%0d dload", k), dload, tbl[k].e_dload);
    end

    // ---------------- simultaneous requests ----------------
`ifdef RAM_ARB_RR_EN
    first_d = 1'b0;   // last grant was data, so instruction goes first
`else
    first_d = 1'b1;
`endif
    first_addr  = first_d ? 32'h0000_2000 : 32'h0000_0200;
    second_addr = first_d ? 32'h0000_0200 : 32'h0000_2000;
    cyc();
    drive(1'b1, 32'h0000_0200, 1'b1, 4'b0000, 32'h0000_2002, 32'h0, 32'hA5A5_0001, 1'b1);
    smp();
    chk("tie idle mem_req", {31'h0, mem_req}, 32'h0);
    cyc();
    smp();
    chk("tie first mem_req", {31'h0, mem_req}, 32'h1);
    chk("tie first mem_addr", mem_addr, first_addr);
    cyc();
    smp();
    chk("tie first iwait", {31'h0, iwait}, {31'h0, first_d});
    chk("tie first dwait", {31'h0, dwait}, {31'h0, ~first_d});
    chk("tie first load", first_d ? dload : iload, 32'hA5A5_0001);
    if (first_d) dren = 1'b0; else iren = 1'b0;
    mem_rdata = 32'h5A5A_0002;
    cyc();
    smp();
    chk("tie gap mem_req", {31'h0, mem_req}, 32'h0);
    cyc();
    smp();
    chk("tie second mem_req", {31'h0, mem_req}, 32'h1);
    chk("tie second mem_addr", mem_addr, second_addr);
    cyc();
    smp();
    chk("tie second wait", {31'h0, (first_d ? iwait : dwait)}, 32'h0);
    chk("tie second load", first_d ? iload : dload, 32'h5A5A_0002);
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // ---------------- reset in the middle of a data access ----------------
    cyc();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_4000, 32'h0, 32'h0, 1'b0);
    smp();
    chk("rst seq idle dwait", {31'h0, dwait}, 32'h1);
    cyc();
    smp();
    chk("rst seq acc mem_req", {31'h0, mem_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst mem_req", {31'h0, mem_req}, 32'h0);
    chk("async rst mem_addr", mem_addr, 32'h0);
    chk("async rst iload", iload, 32'h0000_0013);
    chk("async rst dload", dload, 32'h0);
    cyc();
    rst = 1'b0;
    smp();
    chk("post rst idle mem_req", {31'h0, mem_req}, 32'h0);
    chk("post rst dwait", {31'h0, dwait}, 32'h1);
    cyc();
    smp();
    chk("regrant mem_req", {31'h0, mem_req}, 32'h1);
    chk("regrant mem_addr", mem_addr, 32'h0000_4000);

    // ---------------- request abandoned during the access ----------------
    cyc();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0000_4000, 32'h0, 32'hBEEF_0000, 1'b1);
    smp();
    chk("abandon acc mem_req", {31'h0, mem_req}, 32'h1);
    chk("abandon acc dwait", {31'h0, dwait}, 32'h0);
    cyc();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_6000, 32'h0, 32'h0, 1'b0);
    smp();
    chk("abandon idle mem_req", {31'h0, mem_req}, 32'h0);
    chk("abandon no done dwait", {31'h0, dwait}, 32'h1);
    chk("abandon dload", dload, 32'h0);
    cyc();
    smp();
    chk("after abandon mem_addr", mem_addr, 32'h0000_6000);
    cyc();
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0077;
    smp();
    chk("after abandon acc dwait", {31'h0, dwait}, 32'h1);
    cyc();
    smp();
    chk("after abandon done dwait", {31'h0, dwait}, 32'h0);
    chk("after abandon dload", dload, 32'h0000_0077);
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // ---------------- randomized phase against the model ----------------
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 500; c++) begin
      cyc();
      iren      = ($urandom_range(0, 9) < 6);
      iaddr     = $urandom;
      dren      = ($urandom_range(0, 9) < 4);
      dwen      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      daddr     = $urandom;
      dstore    = $urandom;
      mem_rdata = $urandom;
      mem_ready = ($urandom_range(0, 1) == 1);
      smp();
      model_check(c);
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
